// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU issue arbiter: functional-unit operand/result records,
// default requester count and the result-buffer occupancy states.
package alu_arbiter_pkg;

    localparam int XLEN         = 32;
    localparam int ID_W         = 4;
    localparam int PRD_W        = 6;
    localparam int ALU_ARB_NREQ = 2;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4
    } alu_op_e;

    typedef struct packed {
        alu_op_e              op;
        logic [XLEN-1:0]      rs1;
        logic [XLEN-1:0]      rs2;
        logic [ID_W-1:0]      id;
        logic [PRD_W-1:0]     prd;
        logic [XLEN-1:0]      pc;
    } fu_input_t;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [ID_W-1:0]      id;
        logic [PRD_W-1:0]     prd;
        logic [XLEN-1:0]      rdval;
    } fu_output_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from rr_ptr with wrap;
// rr_ptr moves past the winner on every grant.
module alu_arbiter_rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt     = '0;
        gnt_idx = rr_ptr_q;
        idx     = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PTR_W'((int'(rr_ptr_q) + k) % NREQ);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (found) begin
            rr_ptr_q <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational fu_alu among NREQ issue requesters and buffers results
// in a 2-entry FIFO toward writeback. Define ALU_ARB_PERF_EN for grant/stall counters.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ  = ALU_ARB_NREQ,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  fu_input_t [NREQ-1:0]  req_fuinput_i,
    output fu_input_t             alu_fuinput_o,
    input  fu_output_t            alu_fuoutput_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output fu_output_t            wb_fuoutput_o
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [NREQ-1:0][31:0] perf_grant_cnt_o,
    output logic [31:0]           perf_stall_cnt_o
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    occ_state_e       occ_q, occ_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    fu_output_t       buf_q [DEPTH];
    logic [NREQ-1:0]  gnt;
    logic             push, pop, has_room, grant_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign pop      = wb_valid_o & wb_ready_i;
    assign grant_en = !flush_i && !rst && (has_room || pop);
    assign push     = |gnt;

    alu_arbiter_rr_arbiter #(.NREQ(NREQ)) rr_arbiter (
        .clk (clk),
        .rst (rst),
        .req (req_valid_i),
        .en  (grant_en),
        .gnt (gnt)
    );

    assign req_ready_o = gnt;

    always_comb begin
        alu_fuinput_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) alu_fuinput_o = req_fuinput_i[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) occ_q <= OCC_EMPTY;
        else     occ_q <= occ_d;
    end

    // flush wins over any simultaneous push or pop
    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: if (push) occ_d = OCC_ONE;
                OCC_ONE: begin
                    if (push && !pop)      occ_d = OCC_FULL;
                    else if (!push && pop) occ_d = OCC_EMPTY;
                end
                OCC_FULL:  if (pop && !push) occ_d = OCC_ONE;
                default:   occ_d = OCC_EMPTY;
            endcase
        end
    end

    always_comb begin
        wb_valid_o = (occ_q != OCC_EMPTY);
        has_room   = (occ_q != OCC_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    // result storage carries no reset; occupancy alone qualifies it
    always_ff @(posedge clk) begin
        if (push) buf_q[wr_ptr_q] <= alu_fuoutput_i;
    end

    assign wb_fuoutput_o = buf_q[rd_ptr_q];

`ifdef ALU_ARB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant_cnt_o <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) perf_grant_cnt_o[i] <= sat_inc(perf_grant_cnt_o[i]);
            end
            if (|req_valid_i && !push) perf_stall_cnt_o <= sat_inc(perf_stall_cnt_o);
        end
    end
`else
    // no performance counters in this build
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter (NREQ=2) with a behavioural fu_alu model.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush_i;
    logic [1:0]           req_valid_i;
    logic [1:0]           req_ready_o;
    fu_input_t [1:0]      req_fuinput_i;
    fu_input_t            alu_fuinput_o;
    fu_output_t           alu_fuoutput_i;
    logic                 wb_valid_o;
    logic                 wb_ready_i;
    fu_output_t           wb_fuoutput_o;
`ifdef ALU_ARB_PERF_EN
    logic [1:0][31:0]     perf_grant_cnt_o;
    logic [31:0]          perf_stall_cnt_o;
`endif

    fu_output_t exp_q [$];
    fu_output_t exp_r;
    int         n_cmp  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(2), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_fuinput_i  (req_fuinput_i),
        .alu_fuinput_o  (alu_fuinput_o),
        .alu_fuoutput_i (alu_fuoutput_i),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_fuoutput_o  (wb_fuoutput_o)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grant_cnt_o (perf_grant_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    function automatic fu_output_t alu_model(input fu_input_t f);
        fu_output_t r;
        r.pc  = f.pc;
        r.id  = f.id;
        r.prd = f.prd;
        case (f.op)
            ALU_ADD: r.rdval = f.rs1 + f.rs2;
            ALU_SUB: r.rdval = f.rs1 - f.rs2;
            ALU_AND: r.rdval = f.rs1 & f.rs2;
            ALU_OR:  r.rdval = f.rs1 | f.rs2;
            ALU_XOR: r.rdval = f.rs1 ^ f.rs2;
            default: r.rdval = '0;
        endcase
        return r;
    endfunction

    always_comb alu_fuoutput_i = alu_model(alu_fuinput_o);

    function automatic fu_input_t make_in(input alu_op_e op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] id);
        fu_input_t f;
        f.op  = op;
        f.rs1 = a;
        f.rs2 = b;
        f.id  = id;
        f.prd = {2'b00, id} + 6'd8;
        f.pc  = 32'h1000 + {26'd0, id, 2'b00};
        return f;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; wb_ready_i = 1'b1; req_valid_i = 2'b11;
        req_fuinput_i[0] = make_in(ALU_ADD, 32'd1, 32'd1, 4'd1);
        req_fuinput_i[1] = make_in(ALU_ADD, 32'd2, 32'd2, 4'd2);
        @(negedge clk);
        #1;
        n_cmp++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", req_ready_o); end
        n_cmp++; if (alu_fuinput_o !== '0) begin n_fail++; $display("FAIL reset_aluin got %h want 0", alu_fuinput_o); end
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_wbvalid got %b want 0", wb_valid_o); end
        next_cycle();
        rst = 1'b0; req_valid_i = 2'b00;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        wb_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            req_valid_i = 2'b11;
            req_fuinput_i[0] = make_in(ALU_ADD, 32'(c), 32'd100, 4'(2 * c));
            req_fuinput_i[1] = make_in(ALU_XOR, 32'(3 * c + 1), 32'd5, 4'(2 * c + 1));
            #1;
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++; if (req_ready_o !== exp_g) begin n_fail++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready_o, exp_g); end
            n_cmp++; if (alu_fuinput_o !== req_fuinput_i[c % 2]) begin n_fail++; $display("FAIL rr_aluin c=%0d got %h want %h", c, alu_fuinput_o, req_fuinput_i[c % 2]); end
            n_cmp++; if (wb_valid_o !== (c > 0)) begin n_fail++; $display("FAIL rr_wbvalid c=%0d got %b want %b", c, wb_valid_o, (c > 0)); end
            if (c > 0) begin
                exp_r = exp_q.pop_front();
                n_cmp++; if (wb_fuoutput_o !== exp_r) begin n_fail++; $display("FAIL rr_result c=%0d got %h want %h", c, wb_fuoutput_o, exp_r); end
            end
            exp_q.push_back(alu_model(req_fuinput_i[c % 2]));
            next_cycle();
        end
        req_valid_i = 2'b00;
        #1;
        n_cmp++; if (wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL rr_drain_valid got %b want 1", wb_valid_o); end
        exp_r = exp_q.pop_front();
        n_cmp++; if (wb_fuoutput_o !== exp_r) begin n_fail++; $display("FAIL rr_drain_result got %h want %h", wb_fuoutput_o, exp_r); end
        next_cycle();
        #1;
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL rr_empty got %b want 0", wb_valid_o); end
    endtask

    task automatic test_backpressure();
        wb_ready_i = 1'b0; req_valid_i = 2'b01;
        req_fuinput_i[0] = make_in(ALU_ADD, 32'd5, 32'd7, 4'd3);
        #1;
        n_cmp++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL bp_grant0 got %b want 01", req_ready_o); end
        exp_q.push_back(alu_model(req_fuinput_i[0]));
        next_cycle();
        req_fuinput_i[0] = make_in(ALU_SUB, 32'd20, 32'd6, 4'd4);
        #1;
        n_cmp++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL bp_grant1 got %b want 01", req_ready_o); end
        n_cmp++; if (wb_fuoutput_o.rdval !== 32'd12) begin n_fail++; $display("FAIL bp_rdval got %0d want 12", wb_fuoutput_o.rdval); end
        n_cmp++; if (wb_fuoutput_o.id !== 4'd3) begin n_fail++; $display("FAIL bp_id got %0d want 3", wb_fuoutput_o.id); end
        exp_q.push_back(alu_model(req_fuinput_i[0]));
        next_cycle();
        for (int s = 0; s < 3; s++) begin
            req_fuinput_i[0] = make_in(ALU_OR, 32'(s), 32'h10, 4'd5);
            #1;
            n_cmp++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL bp_full_block s=%0d got %b want 00", s, req_ready_o); end
            n_cmp++; if (wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid s=%0d got %b want 1", s, wb_valid_o); end
            n_cmp++; if (wb_fuoutput_o !== exp_q[0] || wb_fuoutput_o.rdval !== 32'd12) begin n_fail++; $display("FAIL bp_hold s=%0d got %h want %h", s, wb_fuoutput_o, exp_q[0]); end
            next_cycle();
        end
        wb_ready_i = 1'b1;
        req_fuinput_i[0] = make_in(ALU_AND, 32'hF0F0, 32'h0FF0, 4'd6);
        #1;
        n_cmp++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL bp_pushpop got %b want 01", req_ready_o); end
        exp_r = exp_q.pop_front();
        n_cmp++; if (wb_fuoutput_o !== exp_r) begin n_fail++; $display("FAIL bp_pop got %h want %h", wb_fuoutput_o, exp_r); end
        exp_q.push_back(alu_model(req_fuinput_i[0]));
        next_cycle();
        wb_ready_i = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL bp_stays_full got %b want 00", req_ready_o); end
        n_cmp++; if (wb_fuoutput_o !== exp_q[0] || wb_fuoutput_o.rdval !== 32'd14) begin n_fail++; $display("FAIL bp_second got %h want %h", wb_fuoutput_o, exp_q[0]); end
        next_cycle();
    endtask

    task automatic test_flush();
        flush_i = 1'b1; wb_ready_i = 1'b1; req_valid_i = 2'b11;
        req_fuinput_i[0] = make_in(ALU_ADD, 32'd40, 32'd2, 4'd7);
        req_fuinput_i[1] = make_in(ALU_SUB, 32'd50, 32'd8, 4'd8);
        #1;
        n_cmp++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL flush_nogrant got %b want 00", req_ready_o); end
        n_cmp++; if (alu_fuinput_o !== '0) begin n_fail++; $display("FAIL flush_aluin got %h want 0", alu_fuinput_o); end
        next_cycle();
        flush_i = 1'b0;
        exp_q.delete();
        #1;
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_wbvalid got %b want 0", wb_valid_o); end
        n_cmp++; if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL flush_rrptr got %b want 10", req_ready_o); end
        exp_q.push_back(alu_model(req_fuinput_i[1]));
        next_cycle();
        req_valid_i = 2'b00;
        #1;
        n_cmp++; if (wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_refill_valid got %b want 1", wb_valid_o); end
        exp_r = exp_q.pop_front();
        n_cmp++; if (wb_fuoutput_o !== exp_r) begin n_fail++; $display("FAIL flush_refill_result got %h want %h", wb_fuoutput_o, exp_r); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        wb_ready_i = 1'b0; req_valid_i = 2'b01;
        req_fuinput_i[0] = make_in(ALU_XOR, 32'hAA, 32'h55, 4'd9);
        #1;
        n_cmp++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL rst_setup_grant got %b want 01", req_ready_o); end
        next_cycle();
        rst = 1'b1; req_valid_i = 2'b11;
        #1;
        n_cmp++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL rst_mid_ready got %b want 00", req_ready_o); end
        next_cycle();
        rst = 1'b0;
        exp_q.delete();
        req_fuinput_i[0] = make_in(ALU_ADD, 32'd1000, 32'd24, 4'd10);
        req_fuinput_i[1] = make_in(ALU_OR, 32'h100, 32'h1, 4'd11);
        #1;
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wbvalid got %b want 0", wb_valid_o); end
        n_cmp++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL rst_mid_rr got %b want 01", req_ready_o); end
        exp_q.push_back(alu_model(req_fuinput_i[0]));
        next_cycle();
        req_valid_i = 2'b00; wb_ready_i = 1'b1;
        #1;
        exp_r = exp_q.pop_front();
        n_cmp++; if (wb_valid_o !== 1'b1 || wb_fuoutput_o !== exp_r) begin n_fail++; $display("FAIL rst_mid_result got v=%b %h want v=1 %h", wb_valid_o, wb_fuoutput_o, exp_r); end
        next_cycle();
    endtask

`ifdef ALU_ARB_PERF_EN
    task automatic test_perf();
        req_valid_i = 2'b00; rst = 1'b1;
        next_cycle();
        rst = 1'b0; wb_ready_i = 1'b1; req_valid_i = 2'b10;
        for (int g = 0; g < 10; g++) begin
            req_fuinput_i[1] = make_in(ALU_ADD, 32'(g), 32'd1, 4'(g));
            next_cycle();
        end
        flush_i = 1'b1;
        for (int b = 0; b < 4; b++) next_cycle();
        flush_i = 1'b0; req_valid_i = 2'b00;
        #1;
        n_cmp++; if (perf_grant_cnt_o[1] !== 32'd10) begin n_fail++; $display("FAIL perf_grant1 got %0d want 10", perf_grant_cnt_o[1]); end
        n_cmp++; if (perf_grant_cnt_o[0] !== 32'd0) begin n_fail++; $display("FAIL perf_grant0 got %0d want 0", perf_grant_cnt_o[0]); end
        n_cmp++; if (perf_stall_cnt_o !== 32'd4) begin n_fail++; $display("FAIL perf_stall got %0d want 4", perf_stall_cnt_o); end
        next_cycle();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_reset_mid();
`ifdef ALU_ARB_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
